// File: rtl/mips_pkg.sv
// Shared types and sizing for the data-side store buffer.
// Entries hold a word address plus one full data word.
package mips_pkg;
  localparam int SB_DEPTH = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int PW = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [AW-3:0] waddr;
    logic [DW-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// Core data port plus memory write/read port of the store buffer.
// slave is the buffer's view; master is the core/memory side.
interface store_buffer_if;
  import mips_pkg::*;

  logic          cpu_memwrite;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wready;
  logic          buf_empty;

  modport slave (
    input  cpu_memwrite, cpu_addr, cpu_wdata,
    input  mem_rdata, mem_wready,
    output cpu_rdata, cpu_stall, mem_raddr,
    output mem_we, mem_waddr, mem_wdata, buf_empty
  );

  modport master (
    output cpu_memwrite, cpu_addr, cpu_wdata,
    output mem_rdata, mem_wready,
    input  cpu_rdata, cpu_stall, mem_raddr,
    input  mem_we, mem_waddr, mem_wdata, buf_empty
  );
endinterface

// File: rtl/sb_fwd_match.sv
// Load forwarding lookup over the live store buffer entries.
// Youngest matching entry wins; a miss falls back to memory.
module sb_fwd_match
  import mips_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  sb_entry_t [DEPTH-1:0]     i_entries,
  input  logic [$clog2(DEPTH)-1:0]  i_head,
  input  logic [$clog2(DEPTH):0]    i_count,
  input  logic [AW-3:0]             i_waddr,
  output logic                      o_hit,
  output logic [DW-1:0]             o_data
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CW = PTRW + 1;

  logic [PTRW-1:0] w_idx;

  // Scan youngest to oldest; first live match is taken
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_idx = i_head + PTRW'(i);
      if (!o_hit && (CW'(i) < i_count) &&
          (i_entries[w_idx].waddr == i_waddr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core data port and data memory.
// Stores drain in order; loads see the youngest buffered store.
module store_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave sb
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CW = PTRW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  sb_entry_t [DEPTH-1:0] r_entries;
  logic [PTRW-1:0]       r_head;
  logic [PTRW-1:0]       r_tail;
  logic [CW-1:0]         r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_hit;
  logic [DW-1:0] w_fwd_data;
  logic [1:0]    w_unused_addr;

  assign w_unused_addr = sb.cpu_addr[1:0];

  // Reset gates the write port so nothing drains in the reset cycle
  assign w_full        = (r_count == FULL);
  assign sb.mem_we     = ~reset & (r_count != '0);
  assign sb.cpu_stall  = ~reset & sb.cpu_memwrite
                       & w_full & ~sb.mem_wready;
  assign w_push        = ~reset & sb.cpu_memwrite
                       & ~sb.cpu_stall;
  assign w_pop         = sb.mem_we & sb.mem_wready;
  assign sb.buf_empty  = (r_count == '0);

  assign sb.mem_waddr  = {r_entries[r_head].waddr, 2'b00};
  assign sb.mem_wdata  = r_entries[r_head].data;
  assign sb.mem_raddr  = {sb.cpu_addr[AW-1:2], 2'b00};
  assign sb.cpu_rdata  = w_hit ? w_fwd_data : sb.mem_rdata;

  sb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd (
    .i_entries (r_entries),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_waddr   (sb.cpu_addr[AW-1:2]),
    .o_hit     (w_hit),
    .o_data    (w_fwd_data)
  );

  // Entry payload; no reset needed since count gates validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_entries[r_tail].waddr <= sb.cpu_addr[AW-1:2];
      r_entries[r_tail].data  <= sb.cpu_wdata;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: order, stall,
// forwarding, wrap, reset discard and push/pop overlap.
module tb_store_buffer;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;

  store_buffer_if ifc ();

  store_buffer #(
    .DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: checks every cycle, then applies the edge
  always @(negedge clk) begin : mon
    logic        exp_we;
    logic        exp_stall;
    logic [31:0] exp_rd;
    logic [31:0] exp_ra;
    exp_t        e;
    if (reset) begin
      sb_q.delete();
      n_vec++;
      if (ifc.mem_we !== 1'b0) begin
        n_err++;
        $display("FAIL mon_reset_we: got %b want 0", ifc.mem_we);
      end
    end else begin
      exp_we    = (sb_q.size() != 0);
      exp_stall = ifc.cpu_memwrite && (sb_q.size() == 4)
                  && !ifc.mem_wready;
      exp_rd    = ifc.mem_rdata;
      foreach (sb_q[i])
        if (sb_q[i].a == ifc.cpu_addr[31:2]) exp_rd = sb_q[i].d;
      exp_ra = {ifc.cpu_addr[31:2], 2'b00};
      n_vec++;
      if (ifc.mem_we !== exp_we) begin
        n_err++;
        $display("FAIL mon_we: got %b want %b", ifc.mem_we, exp_we);
      end
      n_vec++;
      if (ifc.cpu_stall !== exp_stall) begin
        n_err++;
        $display("FAIL mon_stall: got %b want %b",
                 ifc.cpu_stall, exp_stall);
      end
      n_vec++;
      if (ifc.buf_empty !== !exp_we) begin
        n_err++;
        $display("FAIL mon_empty: got %b want %b",
                 ifc.buf_empty, !exp_we);
      end
      n_vec++;
      if (ifc.cpu_rdata !== exp_rd) begin
        n_err++;
        $display("FAIL mon_rdata: got %h want %h",
                 ifc.cpu_rdata, exp_rd);
      end
      n_vec++;
      if (ifc.mem_raddr !== exp_ra) begin
        n_err++;
        $display("FAIL mon_raddr: got %h want %h",
                 ifc.mem_raddr, exp_ra);
      end
      if (exp_we) begin
        n_vec++;
        if (ifc.mem_waddr !== {sb_q[0].a, 2'b00} ||
            ifc.mem_wdata !== sb_q[0].d) begin
          n_err++;
          $display("FAIL mon_head: got %h/%h want %h/%h",
                   ifc.mem_waddr, ifc.mem_wdata,
                   {sb_q[0].a, 2'b00}, sb_q[0].d);
        end
        if (ifc.mem_wready) void'(sb_q.pop_front());
      end
      if (ifc.cpu_memwrite && !exp_stall) begin
        e.a = ifc.cpu_addr[31:2];
        e.d = ifc.cpu_wdata;
        sb_q.push_back(e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    ifc.cpu_memwrite = 1'b1;
    ifc.cpu_addr     = a;
    ifc.cpu_wdata    = d;
  endtask

  task automatic idle();
    ifc.cpu_memwrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifc.cpu_memwrite = 1'b0;
    ifc.cpu_addr     = '0;
    ifc.cpu_wdata    = '0;
    ifc.mem_rdata    = '0;
    ifc.mem_wready   = 1'b0;
    cyc();
    @(negedge clk);
    n_vec++;
    if (ifc.mem_we !== 1'b0 || ifc.cpu_stall !== 1'b0 ||
        ifc.buf_empty !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: got we=%b st=%b em=%b want 0 0 1",
               ifc.mem_we, ifc.cpu_stall, ifc.buf_empty);
    end
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_single();
    cyc();
    ifc.mem_wready = 1'b1;
    st(32'h10, 32'h1111_1111);
    @(negedge clk);
    n_vec++;
    if (ifc.mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL single_nobypass: got we=%b want 0", ifc.mem_we);
    end
    cyc();
    idle();
    @(negedge clk);
    n_vec++;
    if (ifc.mem_we !== 1'b1 || ifc.mem_waddr !== 32'h10 ||
        ifc.mem_wdata !== 32'h1111_1111) begin
      n_err++;
      $display("FAIL single_write: got %b %h %h want 1 10 11111111",
               ifc.mem_we, ifc.mem_waddr, ifc.mem_wdata);
    end
    cyc();
    @(negedge clk);
    n_vec++;
    if (ifc.buf_empty !== 1'b1) begin
      n_err++;
      $display("FAIL single_empty: got %b want 1", ifc.buf_empty);
    end
  endtask

  task automatic test_fill_stall();
    int k;
    cyc();
    ifc.mem_wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st(32'(i * 4), 32'hC0 + 32'(i));
      @(negedge clk);
      n_vec++;
      if (ifc.cpu_stall !== 1'b0) begin
        n_err++;
        $display("FAIL fill_accept%0d: got stall=%b want 0",
                 i, ifc.cpu_stall);
      end
      cyc();
    end
    st(32'h20, 32'h2020);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if (ifc.cpu_stall !== 1'b1) begin
        n_err++;
        $display("FAIL full_stall%0d: got %b want 1",
                 i, ifc.cpu_stall);
      end
      cyc();
    end
    ifc.mem_wready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ifc.cpu_stall !== 1'b0 || ifc.mem_waddr !== 32'h0) begin
      n_err++;
      $display("FAIL full_pushpop: got st=%b wa=%h want 0 0",
               ifc.cpu_stall, ifc.mem_waddr);
    end
    cyc();
    ifc.mem_wready = 1'b0;
    st(32'h24, 32'h2424);
    @(negedge clk);
    n_vec++;
    if (ifc.cpu_stall !== 1'b1 || ifc.mem_waddr !== 32'h4) begin
      n_err++;
      $display("FAIL still_full: got st=%b wa=%h want 1 4",
               ifc.cpu_stall, ifc.mem_waddr);
    end
    cyc();
    idle();
    ifc.mem_wready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!ifc.buf_empty && k < 10) begin
      cyc();
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (ifc.buf_empty !== 1'b1) begin
      n_err++;
      $display("FAIL fill_drain: timeout empty=%b want 1",
               ifc.buf_empty);
    end
  endtask

  task automatic test_order();
    logic [31:0] wa;
    cyc();
    ifc.mem_wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st(32'(i * 4), 32'h100 + 32'(i));
      cyc();
    end
    idle();
    ifc.mem_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wa = 32'(i * 4);
      @(negedge clk);
      n_vec++;
      if (ifc.mem_we !== 1'b1 || ifc.mem_waddr !== wa) begin
        n_err++;
        $display("FAIL order%0d: got we=%b wa=%h want 1 %h",
                 i, ifc.mem_we, ifc.mem_waddr, wa);
      end
      cyc();
    end
    @(negedge clk);
    n_vec++;
    if (ifc.mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL order_done: got we=%b want 0", ifc.mem_we);
    end
  endtask

  task automatic test_forward();
    cyc();
    ifc.mem_wready = 1'b0;
    st(32'h40, 32'hA);
    cyc();
    st(32'h40, 32'hB);
    cyc();
    idle();
    ifc.cpu_addr  = 32'h40;
    ifc.mem_rdata = 32'hDEAD;
    @(negedge clk);
    n_vec++;
    if (ifc.cpu_rdata !== 32'hB) begin
      n_err++;
      $display("FAIL fwd_young: got %h want b", ifc.cpu_rdata);
    end
    cyc();
    ifc.cpu_addr = 32'h44;
    @(negedge clk);
    n_vec++;
    if (ifc.cpu_rdata !== 32'hDEAD) begin
      n_err++;
      $display("FAIL fwd_miss: got %h want dead", ifc.cpu_rdata);
    end
    cyc();
    ifc.mem_wready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ifc.mem_waddr !== 32'h40 || ifc.mem_wdata !== 32'hA) begin
      n_err++;
      $display("FAIL fwd_drain1: got %h/%h want 40/a",
               ifc.mem_waddr, ifc.mem_wdata);
    end
    cyc();
    @(negedge clk);
    n_vec++;
    if (ifc.mem_waddr !== 32'h40 || ifc.mem_wdata !== 32'hB) begin
      n_err++;
      $display("FAIL fwd_drain2: got %h/%h want 40/b",
               ifc.mem_waddr, ifc.mem_wdata);
    end
    cyc();
    @(negedge clk);
    n_vec++;
    if (ifc.mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL fwd_done: got we=%b want 0", ifc.mem_we);
    end
  endtask

  task automatic test_wrap();
    int k;
    cyc();
    ifc.mem_wready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      st(32'h200 + 32'(i * 4), 32'h6000 + 32'(i));
      cyc();
    end
    idle();
    @(negedge clk);
    n_vec++;
    if (ifc.mem_waddr !== 32'h214 || ifc.mem_wdata !== 32'h6005) begin
      n_err++;
      $display("FAIL wrap_last: got %h/%h want 214/6005",
               ifc.mem_waddr, ifc.mem_wdata);
    end
    k = 0;
    while (!ifc.buf_empty && k < 10) begin
      cyc();
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (ifc.buf_empty !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_drain: timeout empty=%b want 1",
               ifc.buf_empty);
    end
  endtask

  task automatic test_reset_mid();
    cyc();
    ifc.mem_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st(32'h80 + 32'(i * 4), 32'h8000 + 32'(i));
      cyc();
    end
    idle();
    reset         = 1'b1;
    ifc.cpu_addr  = 32'h84;
    ifc.mem_rdata = 32'h1234;
    @(negedge clk);
    n_vec++;
    if (ifc.mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL rst_cycle_we: got %b want 0", ifc.mem_we);
    end
    cyc();
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ifc.mem_we !== 1'b0 || ifc.buf_empty !== 1'b1 ||
        ifc.cpu_rdata !== 32'h1234) begin
      n_err++;
      $display("FAIL rst_discard: got %b %b %h want 0 1 1234",
               ifc.mem_we, ifc.buf_empty, ifc.cpu_rdata);
    end
  endtask

  task automatic test_push_pop();
    cyc();
    ifc.mem_wready = 1'b0;
    st(32'h100, 32'h1);
    cyc();
    st(32'h104, 32'h2);
    cyc();
    st(32'h108, 32'h3);
    ifc.mem_wready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ifc.mem_waddr !== 32'h100 || ifc.cpu_stall !== 1'b0) begin
      n_err++;
      $display("FAIL pp_head: got %h st=%b want 100 0",
               ifc.mem_waddr, ifc.cpu_stall);
    end
    cyc();
    idle();
    ifc.mem_wready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ifc.mem_waddr !== 32'h104 || ifc.mem_wdata !== 32'h2) begin
      n_err++;
      $display("FAIL pp_adv: got %h/%h want 104/2",
               ifc.mem_waddr, ifc.mem_wdata);
    end
    cyc();
    ifc.mem_wready = 1'b1;
    cyc();
    @(negedge clk);
    n_vec++;
    if (ifc.mem_waddr !== 32'h108 || ifc.mem_wdata !== 32'h3) begin
      n_err++;
      $display("FAIL pp_tail_last: got %h/%h want 108/3",
               ifc.mem_waddr, ifc.mem_wdata);
    end
    cyc();
    @(negedge clk);
    n_vec++;
    if (ifc.buf_empty !== 1'b1) begin
      n_err++;
      $display("FAIL pp_count2: got empty=%b want 1", ifc.buf_empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_order();
    test_forward();
    test_wrap();
    test_reset_mid();
    test_push_pop();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the single-cycle core's data port (memwrite, dataadr, writedata, readdata) and data memory.
- Absorbs word stores into an in-order FIFO and drains them to memory whenever memory accepts a write.
- Forwards buffered store data to loads, so the core sees coherent memory.
- Lets the core run at full rate against a data memory whose write port is not always ready.

Parameters:
- DEPTH, 4, number of buffered stores; power of 2, minimum 2.
- AW, 32, byte address width.
- DW, 32, data word width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_memwrite  input  1  core store request this cycle.
- cpu_addr  input  AW  core byte address (ALU result); bits [1:0] ignored.
- cpu_wdata  input  DW  core store data.
- cpu_rdata  output  DW  load data returned to core (combinational).
- cpu_stall  output  1  core must hold PC/state this cycle (store not accepted).
- mem_raddr  output  AW  memory read address = {cpu_addr[AW-1:2],2'b00}.
- mem_rdata  input  DW  memory combinational read data.
- mem_we  output  1  head entry valid; write offered to memory.
- mem_waddr  output  AW  head entry word address, {addr,2'b00}.
- mem_wdata  output  DW  head entry data.
- mem_wready  input  1  memory accepts the offered write this cycle.
- buf_empty  output  1  count==0; used by halt/fence logic.

Behaviour:
- State:
  - entries[DEPTH] of {waddr[AW-1:2], data}
  - head/tail pointers, log2(DEPTH) bits, wrap modulo DEPTH
  - count, 0..DEPTH
- Reset (synchronous): count=0, head=tail=0; mem_we=0, cpu_stall=0, buf_empty=1. Entry contents don't-care.
- Reset mid-operation discards all pending stores. No write is issued in the reset cycle or the cycle after.
- Push = cpu_memwrite & ~cpu_stall. Writes entry[tail], then tail+1.
- Pop = mem_we & mem_wready. Advances head.
- Count update: +1 on push only, -1 on pop only, unchanged when both occur.
- cpu_stall = cpu_memwrite & (count==DEPTH) & ~mem_wready.
  - When full, a simultaneous pop frees a slot and the store is accepted with no stall.
- A store is always buffered, never bypassed directly to memory. Minimum latency from push edge to mem_we=1 is 1 cycle.
- mem_we = (count!=0). mem_waddr/mem_wdata are driven from entries[head] and held stable until popped.
- Stores drain in strict program order. Two stores to the same address both reach memory, oldest first.
- Load forwarding: cpu_rdata = data of the youngest valid entry whose waddr == cpu_addr[AW-1:2], else mem_rdata.
  - Valid = within count, measured from head.
  - The head entry being popped this cycle still counts as valid for the match.
  - A store pushed this same cycle is not visible (the single-cycle core cannot load and store in one instruction).
- Whole-word stores only; no byte enables, no partial merge.
- cpu_rdata is produced every cycle regardless of load/store; the core's memtoreg selects its use.
- The block keeps no combinational path from mem_wready to mem_we. The only combinational path from mem_wready to an output is mem_wready→cpu_stall.

Decomposition:
- Shared package (mips_pkg): DEPTH default, AW/DW, pointer width localparam PW = $clog2(DEPTH), and entry struct {waddr, data}.
- One sub-module, sb_fwd_match: a combinational priority match that scans entries from youngest to oldest and returns hit and data. The FIFO storage and pointers stay in store_buffer.

Test Plan:
- Store 0x11111111 to addr 0x10 with mem_wready=1 → next cycle mem_we=1, mem_waddr=0x10, mem_wdata=0x11111111; one cycle later buf_empty=1.
- mem_wready=0; stores to 0x0,0x4,0x8,0xC → all accepted, cpu_stall=0. A 5th store to 0x20 → cpu_stall=1 until mem_wready=1. In that cycle the stall drops, the store is accepted, and count stays 4.
- mem_wready=0; stores 0xA to 0x40, then 0xB to 0x40; load from 0x40 with mem_rdata=0xDEAD → cpu_rdata=0xB. A load from 0x44 → cpu_rdata=0xDEAD.
- Enable mem_wready=1 with 4 entries queued → memory sees writes 0x0,0x4,0x8,0xC in order on 4 consecutive cycles. With DEPTH=4, pushing 6 stores wraps the pointers and order is preserved.
- Assert reset with 3 entries pending → the next cycle mem_we=0, buf_empty=1, and a load from a pending address returns mem_rdata.
- Simultaneous push and pop at count=2 → count stays 2; the head advances one entry and the new tail entry drains last.
